axi_sub_mem: RTL and testbench
==============================

// Module: axi_sub_mem
// PURPOSE
//  Parametrised AXI single-beat (lite-style) memory subordinate; successor to the fixed-width sub.
//  Owns five channels (AW, W, B, AR, R): buffers write addr/data independently, commits to a byte array
//  with strobes, returns BRESP/RRESP with SLVERR on out-of-range. Sits behind the manager on axi4_if.
// PARAMETERS
//  DATA_W     32    data bus width, bits; multiple of 8, power of two, >=8
//  ADDR_W     32    byte address width
//  MEM_BYTES  4096  memory size in bytes; multiple of DATA_W/8
// PORTS
//  ACLK     in   1          clock, all logic on rising edge
//  ARESETn  in   1          synchronous, active-low reset
//  AWVALID  in   1          write-addr valid;  AWREADY out 1 write-addr ready
//  AWDATA   in   ADDR_W     write byte address
//  WVALID   in   1          write-data valid;  WREADY  out 1 write-data ready
//  WDATA    in   DATA_W     write data
//  WSTRB    in   DATA_W/8   byte-lane enables for WDATA
//  BVALID   out  1          write-resp valid;  BREADY  in  1
//  BDATA    out  2          write response (resp_t)
//  ARVALID  in   1          read-addr valid;   ARREADY out 1
//  ARDATA   in   ADDR_W     read byte address
//  RVALID   out  1          read-data valid;   RREADY  in  1
//  RDATA    out  DATA_W     read data
//  RRESP    out  2          read response (resp_t)
// BEHAVIOUR
//  Reset (ARESETn=0 at edge): all READY/VALID=0, BDATA/RRESP=OKAY, RDATA=0, FSMs->IDLE, holding regs
//   cleared. Memory array NOT reset. READYs rise the first cycle after ARESETn=1. Mid-transaction
//   reset aborts silently: no B/R issued, no partial memory write.
//  Address: word index = addr[ADDR_W-1:$clog2(DATA_W/8)]; low bits ignored (aligned access only).
//   addr >= MEM_BYTES -> SLVERR; no write; RDATA=0.
//  Write path: AW and W captured independently into 1-deep holding regs; AWREADY=!aw_held,
//   WREADY=!w_held. Either order or same cycle accepted.
//   WR_IDLE  : both held -> WR_EXEC.
//   WR_EXEC  : 1 cycle; write lanes with WSTRB=1; compute resp; -> WR_RESP.
//   WR_RESP  : BVALID=1, BDATA stable until BREADY; on BVALID&BREADY clear holds -> WR_IDLE.
//   Min latency: AW+W handshake at edge N -> BVALID high after edge N+2. WSTRB=0 -> OKAY, no change.
//   New AW/W not accepted while held (backpressure via READY=0).
//  Read path:
//   RD_IDLE  : ARREADY=1; on ARVALID&ARREADY latch RDATA/RRESP from array -> RD_DATA.
//   RD_DATA  : ARREADY=0, RVALID=1, RDATA/RRESP stable until RREADY; on handshake -> RD_IDLE.
//   Latency: AR handshake at edge N -> RVALID high after N. Back-to-back: 1 idle cycle between reads.
//  Simultaneous events: read and write paths fully concurrent. AR handshake in same edge as
//   WR_EXEC to same word returns OLD data (read-before-write). BREADY/RREADY may be held high.
//  VALID never depends combinationally on READY; outputs all registered.
// STRUCTURE
//  axi_helper pkg: resp_t {OKAY, EXOKAY, SLVERR, DECERR}; wr_state_t, rd_state_t enums;
//   function addr_ok(addr, MEM_BYTES).
//  Sub-module axi_sub_mem_array: word-organised byte-lane array, 1 write port w/ byte enables,
//   1 async read port; DEPTH=MEM_BYTES/(DATA_W/8). Top holds both FSMs + holding regs.
// TESTING
//  1 Reset: hold ARESETn=0 3 cycles -> all VALID=0, READY=0; cycle after release AWREADY=WREADY=ARREADY=1.
//  2 Write 0xDEADBEEF @0x10 STRB=0xF, AW/W same cycle, BREADY=1 -> BVALID 2 cycles later, BDATA=OKAY;
//    read @0x10 -> RDATA=0xDEADBEEF, RRESP=OKAY.
//  3 W 3 cycles before AW, STRB=0x3, WDATA=0x0000CAFE over 0xDEADBEEF @0x10 -> readback 0xDEADCAFE.
//  4 Write @0x1000 (MEM_BYTES=4096) -> BDATA=SLVERR; read @0x2000 -> RRESP=SLVERR, RDATA=0.
//  5 BREADY/RREADY low 5 cycles -> BVALID/RVALID, BDATA/RDATA held stable; AWREADY/WREADY=0 meanwhile.
//  6 Reset asserted in WR_EXEC (0x11111111 @0x20, prior 0x0) -> no BVALID; read @0x20 returns 0x0;
//    concurrent AR@0x10 during WR_EXEC@0x10 returns pre-write data.

Source files
------------

// File: rtl/axi_sub_mem_pkg.sv
// Shared types for the single-beat AXI memory subordinate: response codes, FSM states, range check.
package axi_sub_mem_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_EXEC,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  localparam int unsigned ADDR_CHK_W = 64;

  // Addresses are zero-extended so one function serves every ADDR_W up to 64.
  function automatic logic addr_ok(input logic [ADDR_CHK_W-1:0] addr,
                                   input logic [ADDR_CHK_W-1:0] mem_bytes);
    return addr < mem_bytes;
  endfunction

endpackage

// File: rtl/axi_sub_mem_array.sv
// Word-organised byte-lane memory: one clocked write port with byte enables, one async read port.
// Write lands at the clock edge, read is combinational; contents are never reset.
module axi_sub_mem_array #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int IDX_W  = $clog2(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [STRB_W-1:0] i_wbe,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (i_wbe[b]) begin
          r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axi_sub_mem.sv
// Single-beat AXI memory subordinate: BVALID two edges after the later AW/W handshake, RVALID the edge of AR.
// Backpressure: AW/W READY drop while a request is held, ARREADY drops while a read response waits for RREADY.
module axi_sub_mem
  import axi_sub_mem_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_BYTES = 4096
) (
  input  logic                i_aclk,
  input  logic                i_aresetn,
  input  logic                i_awvalid,
  output logic                o_awready,
  input  logic [ADDR_W-1:0]   i_awdata,
  input  logic                i_wvalid,
  output logic                o_wready,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  output logic                o_bvalid,
  input  logic                i_bready,
  output resp_t               o_bdata,
  input  logic                i_arvalid,
  output logic                o_arready,
  input  logic [ADDR_W-1:0]   i_ardata,
  output logic                o_rvalid,
  input  logic                i_rready,
  output logic [DATA_W-1:0]   o_rdata,
  output resp_t               o_rresp
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int DEPTH  = MEM_BYTES / STRB_W;
  localparam int IDX_W  = $clog2(DEPTH);

  wr_state_t           r_wr_state;
  logic                r_aw_held;
  logic                r_w_held;
  logic                r_awready;
  logic                r_wready;
  logic [ADDR_W-1:0]   r_awaddr;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_bvalid;
  resp_t               r_bdata;

  rd_state_t           r_rd_state;
  logic                r_arready;
  logic                r_rvalid;
  logic [DATA_W-1:0]   r_rdata;
  resp_t               r_rresp;

  logic                w_wr_ok;
  logic                w_rd_ok;
  logic                w_we;
  logic [IDX_W-1:0]    w_widx;
  logic [IDX_W-1:0]    w_ridx;
  logic [DATA_W-1:0]   w_rword;

  assign w_wr_ok = addr_ok(ADDR_CHK_W'(r_awaddr), ADDR_CHK_W'(MEM_BYTES));
  assign w_rd_ok = addr_ok(ADDR_CHK_W'(i_ardata), ADDR_CHK_W'(MEM_BYTES));
  assign w_widx  = r_awaddr[OFF_W +: IDX_W];
  assign w_ridx  = i_ardata[OFF_W +: IDX_W];

  // Reset gates the commit so a write caught mid-execution never reaches the array.
  assign w_we = (r_wr_state == WR_EXEC) && w_wr_ok && i_aresetn;

  axi_sub_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk   (i_aclk),
    .i_we    (w_we),
    .i_wbe   (r_wstrb),
    .i_waddr (w_widx),
    .i_wdata (r_wdata),
    .i_raddr (w_ridx),
    .o_rdata (w_rword)
  );

  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_wr_state <= WR_IDLE;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awready  <= 1'b0;
      r_wready   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bdata    <= RESP_OKAY;
    end else begin
      if (i_awvalid && r_awready) begin
        r_aw_held <= 1'b1;
        r_awready <= 1'b0;
        r_awaddr  <= i_awdata;
      end else if (!r_aw_held) begin
        r_awready <= 1'b1;
      end

      if (i_wvalid && r_wready) begin
        r_w_held <= 1'b1;
        r_wready <= 1'b0;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end else if (!r_w_held) begin
        r_wready <= 1'b1;
      end

      case (r_wr_state)
        WR_IDLE: begin
          if (r_aw_held && r_w_held) begin
            r_wr_state <= WR_EXEC;
          end
        end
        WR_EXEC: begin
          r_bvalid   <= 1'b1;
          r_bdata    <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
          r_wr_state <= WR_RESP;
        end
        WR_RESP: begin
          // Holds release only once the response is taken, so READY reopens in step with B.
          if (i_bready) begin
            r_bvalid   <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_wr_state <= WR_IDLE;
          end
        end
        default: begin
          r_wr_state <= WR_IDLE;
        end
      endcase
    end
  end

  // Read data is sampled from the array before any same-edge write lands (read-before-write).
  always_ff @(posedge i_aclk) begin
    if (!i_aresetn) begin
      r_rd_state <= RD_IDLE;
      r_arready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rresp    <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (i_arvalid && r_arready) begin
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b1;
            r_rdata    <= w_rd_ok ? w_rword : '0;
            r_rresp    <= w_rd_ok ? RESP_OKAY : RESP_SLVERR;
            r_rd_state <= RD_DATA;
          end else begin
            r_arready <= 1'b1;
          end
        end
        RD_DATA: begin
          if (i_rready) begin
            r_rvalid   <= 1'b0;
            r_arready  <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: begin
          r_rd_state <= RD_IDLE;
        end
      endcase
    end
  end

  assign o_awready = r_awready;
  assign o_wready  = r_wready;
  assign o_bvalid  = r_bvalid;
  assign o_bdata   = r_bdata;
  assign o_arready = r_arready;
  assign o_rvalid  = r_rvalid;
  assign o_rdata   = r_rdata;
  assign o_rresp   = r_rresp;

endmodule

// File: tb/tb_axi_sub_mem.sv
// Bench for axi_sub_mem: directed vector table, hand-built multi-cycle corner cases, randomized traffic vs a byte-array model.
module tb_axi_sub_mem;
  import axi_sub_mem_pkg::*;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int MB = 4096;

  logic          clk = 1'b0;
  logic          aresetn;
  logic          awvalid, awready;
  logic [AW-1:0] awdata;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [3:0]    wstrb;
  logic          bvalid, bready;
  resp_t         bdata;
  logic          arvalid, arready;
  logic [AW-1:0] ardata;
  logic          rvalid, rready;
  logic [DW-1:0] rdata;
  resp_t         rresp;

  always #5 clk = ~clk;

  axi_sub_mem #(.DATA_W(DW), .ADDR_W(AW), .MEM_BYTES(MB)) dut (
    .i_aclk(clk), .i_aresetn(aresetn),
    .i_awvalid(awvalid), .o_awready(awready), .i_awdata(awdata),
    .i_wvalid(wvalid), .o_wready(wready), .i_wdata(wdata), .i_wstrb(wstrb),
    .o_bvalid(bvalid), .i_bready(bready), .o_bdata(bdata),
    .i_arvalid(arvalid), .o_arready(arready), .i_ardata(ardata),
    .o_rvalid(rvalid), .i_rready(rready), .o_rdata(rdata), .o_rresp(rresp)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] mdl [MB];

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdat;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    logic [31:0] raddr;
    logic [1:0]  bresp;
    logic [31:0] rdat;
    logic [1:0]  rrsp;
  } vec_t;

  vec_t vecs[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  function automatic logic [1:0] mdl_resp(input logic [31:0] a);
    return (a < MB) ? 2'b00 : 2'b10;
  endfunction

  task automatic mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int base;
    if (a < MB) begin
      base = int'(a) - int'(a) % 4;
      for (int i = 0; i < 4; i++)
        if (s[i]) mdl[base + i] = d[8*i +: 8];
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    logic [31:0] v;
    int base;
    v = '0;
    if (a < MB) begin
      base = int'(a) - int'(a) % 4;
      for (int i = 0; i < 4; i++) v[8*i +: 8] = mdl[base + i];
    end
    return v;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly, input int stall,
                          output logic [1:0] resp, output int lat);
    bit aw_done, w_done, stable;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11; lat = -1;
    bready = (stall == 0);
    while (!(aw_done && w_done) && cyc < 50) begin
      awvalid = !aw_done && cyc >= aw_dly;
      awdata  = a;
      wvalid  = !w_done && cyc >= w_dly;
      wdata   = d;
      wstrb   = s;
      if (awvalid && awready) aw_done = 1;
      if (wvalid && wready) w_done = 1;
      tick;
      cyc++;
    end
    awvalid = 0;
    wvalid  = 0;
    if (!(aw_done && w_done)) begin
      timeout("aw_w_handshake");
      return;
    end
    lat = 0;
    while (!bvalid && lat < 20) begin
      tick;
      lat++;
    end
    if (!bvalid) begin
      timeout("bvalid_wait");
      return;
    end
    resp = bdata;
    stable = 1;
    for (int k = 0; k < stall; k++) begin
      tick;
      if (!bvalid || bdata !== resp || awready || wready) stable = 0;
    end
    if (stall > 0) check("b_stall_stable", 64'(stable), 64'd1);
    bready = 1;
    tick;
    bready = 0;
    check("b_drop_after_hs", 64'(bvalid), 64'd0);
  endtask

  task automatic do_read(input logic [31:0] a, input int stall,
                         output logic [31:0] d, output logic [1:0] resp, output int lat);
    bit stable;
    int cyc;
    d = 32'hxxxxxxxx; resp = 2'b11; lat = -1; cyc = 0;
    arvalid = 1;
    ardata  = a;
    rready  = (stall == 0);
    while (!arready && cyc < 50) begin
      tick;
      cyc++;
    end
    if (!arready) begin
      arvalid = 0;
      timeout("ar_handshake");
      return;
    end
    tick;
    arvalid = 0;
    lat = 0;
    while (!rvalid && lat < 20) begin
      tick;
      lat++;
    end
    if (!rvalid) begin
      timeout("rvalid_wait");
      return;
    end
    d = rdata;
    resp = rresp;
    stable = 1;
    for (int k = 0; k < stall; k++) begin
      tick;
      if (!rvalid || rdata !== d || rresp !== resp || arready) stable = 0;
    end
    if (stall > 0) check("r_stall_stable", 64'(stable), 64'd1);
    rready = 1;
    tick;
    rready = 0;
    check("r_drop_after_hs", 64'(rvalid), 64'd0);
    check("arready_after_r", 64'(arready), 64'd1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  br, rr;
    logic [31:0] rd;
    int          bl, rl;

    vecs[0] = '{32'h10,       32'hDEADBEEF, 4'hF, 0, 0, 32'h10,       2'b00, 32'hDEADBEEF, 2'b00};
    vecs[1] = '{32'h10,       32'h0000CAFE, 4'h3, 3, 0, 32'h10,       2'b00, 32'hDEADCAFE, 2'b00};
    vecs[2] = '{32'h1000,     32'h55AA55AA, 4'hF, 0, 0, 32'h2000,     2'b10, 32'h0,        2'b10};
    vecs[3] = '{32'h14,       32'hA5A5A5A5, 4'hF, 0, 2, 32'h14,       2'b00, 32'hA5A5A5A5, 2'b00};
    vecs[4] = '{32'h16,       32'h00BB0000, 4'h4, 1, 1, 32'h17,       2'b00, 32'hA5BBA5A5, 2'b00};
    vecs[5] = '{32'h14,       32'hFFFFFFFF, 4'h0, 0, 0, 32'h14,       2'b00, 32'hA5BBA5A5, 2'b00};
    vecs[6] = '{32'hFFC,      32'h01020304, 4'hF, 2, 1, 32'hFFC,      2'b00, 32'h01020304, 2'b00};
    vecs[7] = '{32'hFFFFFFFC, 32'h77777777, 4'hF, 0, 0, 32'hFFFFFFFC, 2'b10, 32'h0,        2'b10};

    aresetn = 0; awvalid = 0; awdata = '0; wvalid = 0; wdata = '0; wstrb = '0;
    bready = 0; arvalid = 0; ardata = '0; rready = 0;

    // Reset held for three edges: everything quiet.
    repeat (3) tick;
    check("rst_awready", 64'(awready), 64'd0);
    check("rst_wready", 64'(wready), 64'd0);
    check("rst_arready", 64'(arready), 64'd0);
    check("rst_bvalid", 64'(bvalid), 64'd0);
    check("rst_rvalid", 64'(rvalid), 64'd0);
    check("rst_bdata", 64'(bdata), 64'd0);
    check("rst_rresp", 64'(rresp), 64'd0);
    check("rst_rdata", 64'(rdata), 64'd0);
    aresetn = 1;
    tick;
    check("rel_awready", 64'(awready), 64'd1);
    check("rel_wready", 64'(wready), 64'd1);
    check("rel_arready", 64'(arready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      do_write(vecs[i].waddr, vecs[i].wdat, vecs[i].strb, vecs[i].aw_dly, vecs[i].w_dly, 0, br, bl);
      check($sformatf("vec%0d_bresp", i), 64'(br), 64'(vecs[i].bresp));
      check($sformatf("vec%0d_blat", i), 64'(bl), 64'd2);
      do_read(vecs[i].raddr, 0, rd, rr, rl);
      check($sformatf("vec%0d_rdata", i), 64'(rd), 64'(vecs[i].rdat));
      check($sformatf("vec%0d_rresp", i), 64'(rr), 64'(vecs[i].rrsp));
      check($sformatf("vec%0d_rlat", i), 64'(rl), 64'd0);
    end

    // Responses held off for five cycles.
    do_write(32'h18, 32'h0BADF00D, 4'hF, 0, 0, 5, br, bl);
    check("stall_bresp", 64'(br), 64'd0);
    do_read(32'h18, 5, rd, rr, rl);
    check("stall_rdata", 64'(rd), 64'h0BADF00D);

    // Reset while the write is executing: no response, no memory change.
    do_write(32'h20, 32'h0, 4'hF, 0, 0, 0, br, bl);
    awvalid = 1; awdata = 32'h20; wvalid = 1; wdata = 32'h11111111; wstrb = 4'hF;
    check("abort_ready", 64'(awready & wready), 64'd1);
    tick;
    awvalid = 0; wvalid = 0;
    tick;
    aresetn = 0;
    repeat (3) tick;
    check("abort_bvalid_in_rst", 64'(bvalid), 64'd0);
    aresetn = 1;
    begin
      bit quiet;
      quiet = 1;
      repeat (4) begin
        tick;
        if (bvalid) quiet = 0;
      end
      check("abort_no_bvalid", 64'(quiet), 64'd1);
    end
    do_read(32'h20, 0, rd, rr, rl);
    check("abort_rdata", 64'(rd), 64'h0);

    // AR handshake on the same edge the write to that word commits: old data returned.
    awvalid = 1; awdata = 32'h10; wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF; bready = 1;
    tick;
    awvalid = 0; wvalid = 0;
    tick;
    arvalid = 1; ardata = 32'h10; rready = 0;
    check("rbw_arready", 64'(arready), 64'd1);
    tick;
    arvalid = 0;
    check("rbw_rvalid", 64'(rvalid), 64'd1);
    check("rbw_rdata_old", 64'(rdata), 64'hDEADCAFE);
    check("rbw_bvalid", 64'(bvalid), 64'd1);
    rready = 1;
    tick;
    rready = 0; bready = 0;
    tick;
    do_read(32'h10, 0, rd, rr, rl);
    check("rbw_rdata_new", 64'(rd), 64'h12345678);

    // Fill the random window so the model and the array agree.
    for (int w = 0; w < 64; w++) begin
      logic [31:0] d;
      d = $urandom;
      do_write(32'(w * 4), d, 4'hF, 0, 0, 0, br, bl);
      mdl_write(32'(w * 4), d, 4'hF);
      check("fill_bresp", 64'(br), 64'd0);
    end

    for (int it = 0; it < 300; it++) begin
      logic [31:0] a, d;
      logic [3:0]  s;
      if ($urandom_range(0, 7) == 0) a = 32'(MB) + $urandom_range(0, 1 << 20);
      else a = $urandom_range(0, 255);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2), br, bl);
        check($sformatf("rnd%0d_bresp@%0h", it, a), 64'(br), 64'(mdl_resp(a)));
        check($sformatf("rnd%0d_blat", it), 64'(bl), 64'd2);
        mdl_write(a, d, s);
      end else begin
        do_read(a, $urandom_range(0, 2), rd, rr, rl);
        check($sformatf("rnd%0d_rdata@%0h", it, a), 64'(rd), 64'(mdl_read(a)));
        check($sformatf("rnd%0d_rresp", it), 64'(rr), 64'(mdl_resp(a)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
